search_ctrl: RTL and testbench

Sequencing controller for the key-search datapath: the 32x3 single-port RAM, the two-register comparator, the result-address register and the read/write address mux. It gates external RAM writes while idle. On start it clears the comparator and result register, then scans RAM addresses 0..DEPTH-1 with one read per cycle. It reports the first matching address through a start/busy/done/found handshake.

---
 rtl/search_ctrl.sv | 148 ++++++++++++++
 tb/tb_search_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/search_ctrl.sv
// search_ctrl: sequences the key-search RAM scan and reports the first matching address.
// Optional SEARCH_COUNT_EN: full scan with a match_cnt output counting every hit.
module search_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int CMP_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              wr_req,
    input  logic              match,
    output logic              ram_we,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              addr_sel,
    output logic              cmp_load,
    output logic              cmp_clr,
    output logic              adr_load,
    output logic              adr_clr,
    output logic [ADDR_W-1:0] hit_addr,
    output logic              busy,
    output logic              done,
    output logic              found
`ifdef SEARCH_COUNT_EN
    ,
    output logic [ADDR_W:0]   match_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [CMP_LAT-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0] tag_q [CMP_LAT];
    logic [ADDR_W-1:0] tag_d [CMP_LAT];
    logic              found_q, found_d;
    logic [ADDR_W-1:0] hit_q, hit_d;
    logic              hit, last_tag;
`ifdef SEARCH_COUNT_EN
    logic [ADDR_W:0]   mcnt_q, mcnt_d;
    assign match_cnt = mcnt_q;
`endif
    // A match level only counts when it lines up with a valid address tag.
    assign hit      = vld_q[CMP_LAT-1] & match;
    assign last_tag = vld_q[CMP_LAT-1] && (tag_q[CMP_LAT-1] == ADDR_W'(DEPTH - 1));
    assign found    = found_q;
    assign hit_addr = hit_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        found_d  = found_q;
        hit_d    = hit_q;
        ram_we   = 1'b0;
        rd_addr  = '0;
        addr_sel = 1'b0;
        cmp_load = 1'b0;
        cmp_clr  = 1'b0;
        adr_load = 1'b0;
        adr_clr  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        vld_d[0] = 1'b0;
        tag_d[0] = cnt_q[ADDR_W-1:0];
        for (int i = 1; i < CMP_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
`ifdef SEARCH_COUNT_EN
        mcnt_d = mcnt_q;
`endif
        case (state_q)
            IDLE: begin
                ram_we  = wr_req & ~start & reset_n;
                state_d = start ? CLEAR : IDLE;
            end
            CLEAR: begin
                cmp_clr = 1'b1;
                adr_clr = 1'b1;
                busy    = 1'b1;
                found_d = 1'b0;
                hit_d   = '0;
                cnt_d   = '0;
                vld_d   = '0;
                state_d = SCAN;
`ifdef SEARCH_COUNT_EN
                mcnt_d  = '0;
`endif
            end
            SCAN: begin
                addr_sel = 1'b1;
                cmp_load = 1'b1;
                busy     = 1'b1;
                rd_addr  = cnt_q[ADDR_W-1:0];
                vld_d[0] = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == (ADDR_W+1)'(DEPTH - 1)) ? DRAIN : SCAN;
            end
            DRAIN: begin
                cmp_load = 1'b1;
                busy     = 1'b1;
                state_d  = last_tag ? DONE : DRAIN;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q == SCAN || state_q == DRAIN) && hit) begin
`ifdef SEARCH_COUNT_EN
            mcnt_d = mcnt_q + 1'b1;
            if (!found_q) begin
                found_d  = 1'b1;
                hit_d    = tag_q[CMP_LAT-1];
                adr_load = 1'b1;
            end
`else
            found_d  = 1'b1;
            hit_d    = tag_q[CMP_LAT-1];
            adr_load = 1'b1;
            vld_d    = '0;
            state_d  = DONE;
`endif
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_q   <= '0;
            found_q <= 1'b0;
            hit_q   <= '0;
            for (int i = 0; i < CMP_LAT; i++) tag_q[i] <= '0;
`ifdef SEARCH_COUNT_EN
            mcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            found_q <= found_d;
            hit_q   <= hit_d;
            for (int i = 0; i < CMP_LAT; i++) tag_q[i] <= tag_d[i];
`ifdef SEARCH_COUNT_EN
            mcnt_q  <= mcnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_search_ctrl.sv
// tb_search_ctrl: directed bench with a RAM/comparator model and a result scoreboard.
module tb_search_ctrl;
`ifdef SEARCH_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, wr_req = 1'b0, match;
    logic ram_we, addr_sel, cmp_load, cmp_clr, adr_load, adr_clr, busy, done, found;
    logic [4:0] rd_addr, hit_addr, wr_addr = '0;
    logic [2:0] wr_data = '0, key = '0, rdata_q = '0;
    logic [2:0] mem [32];
    logic match_m = 1'b0, stale = 1'b0;
`ifdef SEARCH_COUNT_EN
    logic [5:0] match_cnt;
`endif
    int cyc = 0, passed = 0, failed = 0, total = 0;
    typedef struct { int lat; bit f; int a; int n; } exp_t;
    exp_t sb[$];

    search_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .wr_req(wr_req), .match(match),
        .ram_we(ram_we), .rd_addr(rd_addr), .addr_sel(addr_sel), .cmp_load(cmp_load),
        .cmp_clr(cmp_clr), .adr_load(adr_load), .adr_clr(adr_clr), .hit_addr(hit_addr),
        .busy(busy), .done(done), .found(found)
`ifdef SEARCH_COUNT_EN
        , .match_cnt(match_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Datapath model: RAM read register then comparator register.
    always @(posedge clk) begin
        if (ram_we && !addr_sel) mem[wr_addr] <= wr_data;
        rdata_q <= mem[addr_sel ? rd_addr : wr_addr];
        if (cmp_clr) match_m <= 1'b0;
        else if (cmp_load) match_m <= (rdata_q == key);
    end
    assign match = match_m | stale;

    function automatic logic [31:0] outs();
        return {13'd0, ram_we, rd_addr, addr_sel, cmp_load, cmp_clr, adr_load, adr_clr,
                hit_addr, busy, done, found};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [2:0] d);
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = 5'(a); wr_data = d;
        #1 chk("idle_write_we", {31'd0, ram_we}, 1);
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    task automatic search(input string nm, input bit stl, input bit sw, input bit scan_wr,
                          input int lat, input bit f, input int a, input int n);
        int t0, rel, nxt, serr;
        bit seen;
        exp_t e;
        nxt = 0; serr = 0; seen = 1'b0;
        key = 3'b101;
        @(posedge clk); #1;
        start = 1'b1; stale = stl; t0 = cyc;
        if (sw) begin
            wr_req = 1'b1; wr_addr = 5'd0; wr_data = 3'b101;
            #1 chk({nm, "_start_wr_we"}, {31'd0, ram_we}, 0);
        end
        sb.push_back('{lat, f, a, n});
        @(posedge clk); #1;
        start = 1'b0; wr_req = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (rel >= 3) stale = 1'b0;
            if (rel == 1) chk({nm, "_busy_first"}, {31'd0, busy}, 1);
            if (addr_sel) begin
                if (rd_addr !== 5'(nxt)) serr++;
                nxt++;
            end
            if (scan_wr && rel == 5) begin
                wr_req = 1'b1;
                #1 chk({nm, "_scan_wr_we"}, {31'd0, ram_we}, 0);
            end
            if (rel == 6) wr_req = 1'b0;
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk({nm, "_done_cycle"}, rel, e.lat);
                chk({nm, "_found"}, {31'd0, found}, {31'd0, e.f});
                chk({nm, "_hit_addr"}, {27'd0, hit_addr}, e.a);
                chk({nm, "_busy_at_done"}, {31'd0, busy}, 0);
                chk({nm, "_sweep_order"}, serr, 0);
                if (e.lat == 36) chk({nm, "_sweep_len"}, nxt, 32);
`ifdef SEARCH_COUNT_EN
                chk({nm, "_match_cnt"}, {26'd0, match_cnt}, e.n);
`endif
            end
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'd0, done}, 0);
        chk({nm, "_found_hold"}, {31'd0, found}, {31'd0, f});
    endtask

    initial begin
        int t0, dn;
        for (int i = 0; i < 32; i++) mem[i] = 3'b000;
        #2 chk("reset_outputs", outs(), 0);
        @(negedge clk); reset_n = 1'b1;
        wr(5, 3'b101);
        search("hit5", 1'b0, 1'b0, 1'b0, CNT ? 36 : 10, 1'b1, 5, 1);
        wr(5, 3'b011);
        search("miss", 1'b0, 1'b0, 1'b0, 36, 1'b0, 0, 0);
        wr(3, 3'b101);
        wr(20, 3'b101);
        search("two", 1'b0, 1'b0, 1'b0, CNT ? 36 : 8, 1'b1, 3, 2);
        wr(3, 3'b001);
        wr(20, 3'b111);
        wr(31, 3'b101);
        search("last_stale", 1'b1, 1'b0, 1'b0, 36, 1'b1, 31, 1);
        search("start_wr", 1'b0, 1'b1, 1'b1, 36, 1'b1, 31, 1);
        // Abort a scan with reset at cycle 12.
        @(posedge clk); #1;
        start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc - t0 < 12) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 chk("midreset_outputs", outs(), 0);
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("midreset_no_done", dn, 0);
        reset_n = 1'b1;
        search("after_reset", 1'b0, 1'b0, 1'b0, 36, 1'b1, 31, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
